mv_input_loader: RTL and testbench

- Receive side of the matrix-vector input stream: 14-bit signed words, a valid/ready handshake, and a per-word new_matrix flag.
- Stores a KxK matrix in a local memory and a K-element vector in registers, then hands one job at a time to the matvec compute datapath.
- Sits between the external input port and the MAC/accumulator pipeline; it is the consumer the stream generator talks to.

---
 rtl/mv_pkg.sv | 21 ++
 rtl/mv_mat_mem.sv | 31 +++
 rtl/mv_input_loader.sv | 167 ++++++++++++++++
 tb/tb_mv_input_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mv_pkg.sv
// Shared types and sizing for the matrix-vector input loader.
package mv_pkg;

  localparam int K  = 8;
  localparam int IW = 14;
  localparam int OW = 2 * IW;
  localparam int NW = K * K;
  localparam int AW = $clog2(NW);

  typedef logic signed [IW-1:0] data_t;
  typedef logic [AW-1:0]        addr_t;
  typedef logic signed [OW-1:0] acc_t;

  typedef enum logic [1:0] {
    GROUP_START = 2'd0,
    LOAD_M      = 2'd1,
    LOAD_X      = 2'd2,
    BUSY        = 2'd3
  } ld_state_t;

endpackage

// File: rtl/mv_mat_mem.sv
// KxK matrix store: one write port, one registered read port, cleared by reset.
module mv_mat_mem #(
  parameter int DEPTH = 64,
  parameter int W     = 14,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mv_input_loader.sv
// Input-stream loader: fills the matrix memory and vector registers, then offers one job.
// Optional macro MVL_DBLBUF_EN adds a shadow vector that can load while a job is busy.
module mv_input_loader #(
  parameter int K  = 8,
  parameter int IW = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [IW-1:0]          input_data,
  input  logic                   new_matrix,
  output logic                   job_valid,
  input  logic                   job_done,
  input  logic [$clog2(K*K)-1:0] m_raddr,
  output logic [IW-1:0]          m_rdata,
  output logic [K*IW-1:0]        x_flat
);
  import mv_pkg::*;

  localparam int NW  = K * K;
  localparam int AW  = $clog2(NW);
  localparam int CW  = $clog2(NW + 1);
  localparam int XIW = $clog2(K);

  ld_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] x_q [K];
  logic [IW-1:0] x_d [K];
  logic          ready_raw;
  logic          xfer;
  logic          mem_we;

`ifdef MVL_DBLBUF_EN
  localparam int XCW = $clog2(K + 1);
  logic [IW-1:0]  xsh_q [K];
  logic [IW-1:0]  xsh_d [K];
  logic [XCW-1:0] shc_q, shc_d;
`endif

  // A new-matrix group arriving while busy is held off, not queued in the shadow.
  always_comb begin
    ready_raw = 1'b1;
    if (state_q == BUSY) begin
`ifdef MVL_DBLBUF_EN
      ready_raw = (shc_q != XCW'(K)) &&
                  !((shc_q == '0) && input_valid && new_matrix);
`else
      ready_raw = 1'b0;
`endif
    end
  end

  assign input_ready = reset && ready_raw;
  assign xfer        = input_valid && input_ready;
  assign mem_we      = xfer && (((state_q == GROUP_START) && new_matrix) ||
                                (state_q == LOAD_M));
  assign job_valid   = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    case (state_q)
      GROUP_START: begin
        if (xfer) begin
          cnt_d = CW'(1);
          if (new_matrix) begin
            state_d = LOAD_M;
          end else begin
            x_d[0]  = input_data;
            state_d = LOAD_X;
          end
        end
      end
      LOAD_M: begin
        if (xfer) begin
          if (cnt_q == CW'(NW - 1)) begin
            cnt_d   = '0;
            state_d = LOAD_X;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_X: begin
        if (xfer) begin
          x_d[cnt_q[XIW-1:0]] = input_data;
          if (cnt_q == CW'(K - 1)) begin
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      BUSY: begin
        if (job_done) state_d = GROUP_START;
      end
    endcase

`ifdef MVL_DBLBUF_EN
    xsh_d = xsh_q;
    shc_d = shc_q;
    if ((state_q == BUSY) && xfer) begin
      xsh_d[shc_q[XIW-1:0]] = input_data;
      shc_d = shc_q + XCW'(1);
    end
    // A partially loaded shadow group resumes in LOAD_X once the job retires.
    if ((state_q == BUSY) && job_done) begin
      if (shc_d == XCW'(K)) begin
        x_d     = xsh_d;
        shc_d   = '0;
        state_d = BUSY;
      end else if (shc_d != '0) begin
        x_d     = xsh_d;
        cnt_d   = CW'(shc_d);
        shc_d   = '0;
        state_d = LOAD_X;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GROUP_START;
      cnt_q   <= '0;
      for (int i = 0; i < K; i++) x_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

`ifdef MVL_DBLBUF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shc_q <= '0;
      for (int i = 0; i < K; i++) xsh_q[i] <= '0;
    end else begin
      shc_q <= shc_d;
      xsh_q <= xsh_d;
    end
  end
`endif

  for (genvar g = 0; g < K; g++) begin : g_xflat
    assign x_flat[g*IW +: IW] = x_q[g];
  end

  mv_mat_mem #(
    .DEPTH (NW),
    .W     (IW),
    .AW    (AW)
  ) u_mat_mem (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (mem_we),
    .waddr_i (cnt_q[AW-1:0]),
    .wdata_i (input_data),
    .raddr_i (m_raddr),
    .rdata_o (m_rdata)
  );

endmodule

// File: tb/tb_mv_input_loader.sv
// Self-checking bench for mv_input_loader: group-level model plus hand-computed pins.
// Build with +define+MVL_DBLBUF_EN to also cover the shadow-vector path.
module tb_mv_input_loader;

  localparam int K  = 8;
  localparam int IW = 14;
  localparam int NW = K * K;

  logic                   clk;
  logic                   reset;
  logic                   input_valid;
  logic                   input_ready;
  logic [IW-1:0]          input_data;
  logic                   new_matrix;
  logic                   job_valid;
  logic                   job_done;
  logic [$clog2(NW)-1:0]  m_raddr;
  logic [IW-1:0]          m_rdata;
  logic [K*IW-1:0]        x_flat;

  int checkCount = 0;
  int errCount   = 0;

  mv_input_loader #(.K(K), .IW(IW)) dut (
    .clk         (clk),
    .reset       (reset),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .input_data  (input_data),
    .new_matrix  (new_matrix),
    .job_valid   (job_valid),
    .job_done    (job_done),
    .m_raddr     (m_raddr),
    .m_rdata     (m_rdata),
    .x_flat      (x_flat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Group-level reference: words are counted per group, a group is 72 words when it
  // opens with new_matrix, otherwise 8, and a completed group means a job is pending.
  logic [IW-1:0] mMat [NW];
  logic [IW-1:0] mX   [K];
  logic [IW-1:0] mSh  [K];
  logic [IW-1:0] mRdata;
  int            mPos;
  int            mShCnt;
  bit            mBusy;
  bit            mGrpMat;

  function automatic bit modelReady();
    if (!mBusy) return 1'b1;
`ifdef MVL_DBLBUF_EN
    return (mShCnt < K) && !(mShCnt == 0 && input_valid && new_matrix);
`else
    return 1'b0;
`endif
  endfunction

  initial begin : model
    bit wasBusy;
    bit rdy;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int i = 0; i < NW; i++) mMat[i] = '0;
        for (int i = 0; i < K; i++) begin
          mX[i]  = '0;
          mSh[i] = '0;
        end
        mRdata  = '0;
        mPos    = 0;
        mShCnt  = 0;
        mBusy   = 1'b0;
        mGrpMat = 1'b0;
      end else begin
        wasBusy = mBusy;
        rdy     = modelReady();
        mRdata  = mMat[m_raddr];
        if (input_valid && rdy) begin
          if (!wasBusy) begin
            if (mPos == 0) mGrpMat = new_matrix;
            if (mGrpMat && mPos < NW) mMat[mPos] = input_data;
            else mX[mPos - (mGrpMat ? NW : 0)] = input_data;
            mPos++;
            if (mPos == (mGrpMat ? NW + K : K)) begin
              mBusy = 1'b1;
              mPos  = 0;
            end
          end else begin
            mSh[mShCnt] = input_data;
            mShCnt++;
          end
        end
        if (wasBusy && job_done) begin
          if (mShCnt == K) begin
            for (int i = 0; i < K; i++) mX[i] = mSh[i];
          end else begin
            mBusy = 1'b0;
            if (mShCnt > 0) begin
              for (int i = 0; i < mShCnt; i++) mX[i] = mSh[i];
              mPos    = mShCnt;
              mGrpMat = 1'b0;
            end
          end
          mShCnt = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: handshake and job flag against the model, job contents while busy.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("rstReady", 32'(input_ready), 32'd0);
        checkOutput("rstJobValid", 32'(job_valid), 32'd0);
      end else begin
        checkOutput("ready", 32'(input_ready), 32'(modelReady()));
        checkOutput("jobValid", 32'(job_valid), 32'(mBusy));
        if (mBusy) begin
          for (int k = 0; k < K; k++)
            checkOutput("xElem", 32'(x_flat[k*IW +: IW]), 32'(mX[k]));
          checkOutput("mRdata", 32'(m_rdata), 32'(mRdata));
        end
      end
    end
  end

  // Entered and left at posedge+1; holds one word until the DUT takes it.
  task automatic applyStimulus(input logic [IW-1:0] d, input logic nm, input int gapPct);
    bit rdy;
    int tries;
    while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
      input_valid = 1'b0;
      input_data  = 'x;
      new_matrix  = 1'bx;
      @(posedge clk);
      #1;
    end
    input_valid = 1'b1;
    input_data  = d;
    new_matrix  = nm;
    tries = 0;
    forever begin
      @(negedge clk);
      rdy = input_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      tries++;
      if (tries > 200) begin
        checkCount++;
        errCount++;
        $display("[TB] FAIL handshakeTimeout: got ready=0 for 200 cycles expected a transfer");
        break;
      end
    end
    input_valid = 1'b0;
    input_data  = 'x;
    new_matrix  = 1'bx;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseJobDone();
    job_done = 1'b1;
    nextCycle();
    job_done = 1'b0;
  endtask

  task automatic readMat(input int addr, input logic [IW-1:0] exp, input string nm);
    m_raddr = addr[$clog2(NW)-1:0];
    @(posedge clk);
    @(negedge clk);
    checkOutput(nm, 32'(m_rdata), 32'(exp));
    nextCycle();
  endtask

  initial begin : main
    logic [IW-1:0] w;
    reset       = 1'b0;
    input_valid = 1'b0;
    input_data  = '0;
    new_matrix  = 1'b0;
    job_done    = 1'b0;
    m_raddr     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("relReady", 32'(input_ready), 32'd1);
    checkOutput("relJobValid", 32'(job_valid), 32'd0);
    checkOutput("relXflatZero", 32'(x_flat == '0), 32'd1);
    checkOutput("relRdata", 32'(m_rdata), 32'd0);
    nextCycle();

    // Group 1: matrix 1..64, vector 1..8.
    for (int i = 0; i < NW; i++) applyStimulus(IW'(i + 1), i == 0, 0);
    for (int i = 0; i < K - 1; i++) applyStimulus(IW'(i + 1), 1'b0, 0);
    @(negedge clk);
    checkOutput("g1PreLastJv", 32'(job_valid), 32'd0);
    nextCycle();
    applyStimulus(IW'(8), 1'b0, 0);
    @(negedge clk);
    checkOutput("g1Latency", 32'(job_valid), 32'd1);
    checkOutput("g1X7", 32'(x_flat[7*IW +: IW]), 32'd8);
`ifndef MVL_DBLBUF_EN
    checkOutput("g1BusyReady", 32'(input_ready), 32'd0);
`endif
    nextCycle();
    readMat(9, IW'(10), "g1Addr9");
    repeat (3) nextCycle();
    pulseJobDone();
    @(negedge clk);
    checkOutput("g1DoneJv", 32'(job_valid), 32'd0);
    nextCycle();

    // Group 2: vector of -1, matrix reused.
    for (int i = 0; i < K; i++) applyStimulus(14'h3FFF, 1'b0, 0);
    @(negedge clk);
    checkOutput("g2X0", 32'(x_flat[0 +: IW]), 32'h3FFF);
    checkOutput("g2X5", 32'(x_flat[5*IW +: IW]), 32'h3FFF);
    nextCycle();
    readMat(63, IW'(64), "g2Addr63");
    pulseJobDone();

    // Group 3: random gaps, X while idle, a stray mid-group new_matrix.
    for (int i = 0; i < NW; i++) begin
      w = IW'(i * 37 + 5000);
      applyStimulus(w, (i == 0) || (i == 20), 50);
    end
    for (int i = 0; i < K; i++) applyStimulus(IW'(14'h2000 + i), 1'b0, 50);
    @(negedge clk);
    checkOutput("g3Jv", 32'(job_valid), 32'd1);
    checkOutput("g3X0", 32'(x_flat[0 +: IW]), 32'h2000);
    nextCycle();
    readMat(20, 14'h166C, "g3Addr20");
    for (int a = 0; a < NW; a++) begin
      m_raddr = a[$clog2(NW)-1:0];
      nextCycle();
    end
    pulseJobDone();

    // Group 4: reset after 30 matrix words, then a plain vector group.
    for (int i = 0; i < 30; i++) applyStimulus(IW'(100 + i), i == 0, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midRstReady", 32'(input_ready), 32'd0);
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRelReady", 32'(input_ready), 32'd1);
    nextCycle();
    for (int i = 0; i < K; i++) applyStimulus(IW'(2), 1'b0, 0);
    @(negedge clk);
    checkOutput("g4Jv", 32'(job_valid), 32'd1);
    checkOutput("g4X3", 32'(x_flat[3*IW +: IW]), 32'd2);
    nextCycle();
    readMat(5, IW'(0), "g4Addr5Cleared");
    readMat(20, IW'(0), "g4Addr20Cleared");
    pulseJobDone();

    // Group 5: job_done during vector load must be ignored.
    for (int i = 0; i < K; i++) begin
      if (i == 3) job_done = 1'b1;
      applyStimulus(IW'(7 * i - 20), 1'b0, 0);
      job_done = 1'b0;
    end
    @(negedge clk);
    checkOutput("g5JdIgnored", 32'(job_valid), 32'd1);
    checkOutput("g5X7", 32'(x_flat[7*IW +: IW]), 32'd29);
    nextCycle();

`ifdef MVL_DBLBUF_EN
    // Shadow group of fives during BUSY, swapped in on job_done.
    for (int i = 0; i < K; i++) applyStimulus(IW'(5), 1'b0, 0);
    @(negedge clk);
    checkOutput("dbFullReady", 32'(input_ready), 32'd0);
    checkOutput("dbOldX0", 32'(x_flat[0 +: IW]), 32'h3FEC);
    nextCycle();
    pulseJobDone();
    @(negedge clk);
    checkOutput("dbB2bJv", 32'(job_valid), 32'd1);
    checkOutput("dbX0", 32'(x_flat[0 +: IW]), 32'd5);
    checkOutput("dbX7", 32'(x_flat[7*IW +: IW]), 32'd5);
    nextCycle();
`endif

    pulseJobDone();
    @(negedge clk);
    checkOutput("endJv", 32'(job_valid), 32'd0);
    nextCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule
